// File: rtl/board_led_pkg.sv
// rtl/board_led_pkg.sv - shared display-mode encoding for the board LED status block
package board_led_pkg;

  typedef enum logic [1:0] {
    LED_MODE_DIRECT  = 2'd0,
    LED_MODE_STRETCH = 2'd1,
    LED_MODE_BLINK   = 2'd2,
    LED_MODE_TOGGLE  = 2'd3
  } led_mode_e;

  localparam int LED_MODE_W = 2;

endpackage

// File: rtl/board_led_channel.sv
// rtl/board_led_channel.sv - one LED channel: synchroniser, edge detect, stretch/toggle state, mode mux
module board_led_channel
  import board_led_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int STRETCH_CYCLES = 1200000,
  parameter bit IDLE           = 1'b0,
  parameter bit LED_ACTIVE_LOW = 1'b0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  sig,
  input  logic [LED_MODE_W-1:0] mode,
  input  logic                  phase,
  output logic                  led
);

  localparam int                CNT_W    = $clog2(STRETCH_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(STRETCH_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s_last;
  logic                   prev;
  logic [CNT_W-1:0]       cnt;
  logic                   tgl;
  logic                   any_edge;
  logic                   rise_edge;
  logic                   on;

  assign s_last    = sync[SYNC_STAGES-1];
  assign any_edge  = s_last ^ prev;
  assign rise_edge = s_last & ~prev;

  // cnt and tgl run in every mode so switching modes never loses state
  always_ff @(posedge clock) begin
    if (reset) begin
      sync <= {SYNC_STAGES{IDLE}};
      prev <= IDLE;
      cnt  <= '0;
      tgl  <= 1'b0;
      led  <= LED_ACTIVE_LOW;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], sig};
      prev <= s_last;
      if (any_edge) begin
        cnt <= CNT_LOAD;
      end else if (cnt != '0) begin
        cnt <= cnt - CNT_ONE;
      end
      if (rise_edge) begin
        tgl <= ~tgl;
      end
      led <= on ^ LED_ACTIVE_LOW;
    end
  end

  always_comb begin
    on = 1'b0;
    case (led_mode_e'(mode))
      LED_MODE_DIRECT:  on = prev;
      LED_MODE_STRETCH: on = (cnt != '0);
      LED_MODE_BLINK:   on = prev & phase;
      LED_MODE_TOGGLE:  on = tgl;
      default:          on = 1'b0;
    endcase
  end

endmodule

// File: rtl/board_led_status.sv
// rtl/board_led_status.sv - board status LEDs: shared blink prescaler plus NUM_LEDS display channels
module board_led_status
  import board_led_pkg::*;
#(
  parameter int                  NUM_LEDS          = 4,
  parameter int                  SYNC_STAGES       = 2,
  parameter int                  STRETCH_CYCLES    = 1200000,
  parameter int                  BLINK_HALF_CYCLES = 6000000,
  parameter logic [NUM_LEDS-1:0] IDLE_LEVEL        = {NUM_LEDS{1'b0}},
  parameter bit                  LED_ACTIVE_LOW    = 1'b0
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [NUM_LEDS-1:0]              sig_i,
  input  logic [LED_MODE_W*NUM_LEDS-1:0]   mode_i,
  output logic [NUM_LEDS-1:0]              led_o
);

  localparam int               PRE_W    = $clog2(BLINK_HALF_CYCLES);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(BLINK_HALF_CYCLES - 1);
  localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);

  logic [PRE_W-1:0] prescale;
  logic             phase;

  // One prescaler for all channels keeps every blinking LED in step
  always_ff @(posedge clock) begin
    if (reset) begin
      prescale <= '0;
      phase    <= 1'b0;
    end else if (prescale == PRE_LAST) begin
      prescale <= '0;
      phase    <= ~phase;
    end else begin
      prescale <= prescale + PRE_ONE;
    end
  end

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
    board_led_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .STRETCH_CYCLES (STRETCH_CYCLES),
      .IDLE           (IDLE_LEVEL[i]),
      .LED_ACTIVE_LOW (LED_ACTIVE_LOW)
    ) u_ch (
      .clock (clock),
      .reset (reset),
      .sig   (sig_i[i]),
      .mode  (mode_i[LED_MODE_W*i +: LED_MODE_W]),
      .phase (phase),
      .led   (led_o[i])
    );
  end

endmodule

// File: tb/tb_board_led_status.sv
// tb/tb_board_led_status.sv - checks active-high and active-low builds against a history-based model
module tb_board_led_status;

  localparam int         N    = 4;
  localparam int         SS   = 2;
  localparam int         SC   = 8;
  localparam int         BH   = 4;
  localparam logic [3:0] IDLE = 4'b0100;
  localparam int         HMAX = 4096;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] sig   = IDLE;
  logic [7:0] mode  = 8'h55;
  logic [3:0] led;
  logic [3:0] led_n;

  int total = 0;
  int bad   = 0;
  int ecount = 0;
  int hi1 = 0;
  int hi2 = 0;

  bit [3:0] xh [0:HMAX-1];
  bit [7:0] mh [0:HMAX-1];
  bit       rh [0:HMAX-1];

  board_led_status #(
    .NUM_LEDS(N), .SYNC_STAGES(SS), .STRETCH_CYCLES(SC), .BLINK_HALF_CYCLES(BH),
    .IDLE_LEVEL(IDLE), .LED_ACTIVE_LOW(1'b0)
  ) dut (
    .clock(clock), .reset(reset), .sig_i(sig), .mode_i(mode), .led_o(led)
  );

  board_led_status #(
    .NUM_LEDS(N), .SYNC_STAGES(SS), .STRETCH_CYCLES(SC), .BLINK_HALF_CYCLES(BH),
    .IDLE_LEVEL(IDLE), .LED_ACTIVE_LOW(1'b1)
  ) dut_n (
    .clock(clock), .reset(reset), .sig_i(sig), .mode_i(mode), .led_o(led_n)
  );

  always #5 clock = ~clock;

  // Record what every edge saw; the model works purely from this history
  always @(posedge clock) begin
    ecount++;
    if (ecount < HMAX) begin
      xh[ecount] = sig;
      mh[ecount] = mode;
      rh[ecount] = reset;
    end
  end

  // Input value as seen by the channel for edge k, given last reset edge r
  function automatic bit vbit(int k, int r, int i);
    if (k <= r) return IDLE[i];
    return xh[k][i];
  endfunction

  // Expected active-high LED word after edge e
  function automatic logic [3:0] exp_led(int e);
    int r;
    logic [3:0] res;
    res = 4'b0000;
    if (rh[e]) return res;
    r = e;
    while (r > 0 && !rh[r]) r--;
    for (int i = 0; i < N; i++) begin
      bit on;
      int c;
      int lo;
      on = 1'b0;
      case (mh[e][2*i +: 2])
        2'd0: on = vbit(e - 1 - SS, r, i);
        2'd1: begin
          lo = (e - SC > r + 1) ? e - SC : r + 1;
          for (int d = lo; d <= e - 1; d++)
            if (vbit(d - SS, r, i) != vbit(d - SS - 1, r, i)) on = 1'b1;
        end
        2'd2: on = vbit(e - 1 - SS, r, i) & ((((e - 1 - r) / BH) % 2) == 1);
        default: begin
          c = 0;
          for (int d = r + 1; d <= e - 1; d++)
            if (vbit(d - SS, r, i) && !vbit(d - SS - 1, r, i)) c++;
          on = (c % 2) == 1;
        end
      endcase
      res[i] = on;
    end
    return res;
  endfunction

  task automatic tick();
    logic [3:0] ex;
    @(negedge clock);
    if (ecount > 0 && ecount < HMAX) begin
      ex = exp_led(ecount);
      total++;
      assert (led === ex) else begin
        bad++;
        $error("FAIL led edge=%0d observed=%b expected=%b", ecount, led, ex);
      end
      total++;
      assert (led_n === ~ex) else begin
        bad++;
        $error("FAIL led_n edge=%0d observed=%b expected=%b", ecount, led_n, ~ex);
      end
    end
    if (led[1]) hi1++;
    if (led[2]) hi2++;
  endtask

  task automatic chk(input string tag, input int obs, input int expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  initial begin
    // Reset with ch2 idling high, all channels in stretch mode
    repeat (3) tick();
    chk("reset_led", int'(led), 0);
    chk("reset_led_n", int'(led_n), 15);
    reset = 1'b0;
    repeat (12) tick();
    chk("no_spurious_ch2", int'(led), 0);

    mode = 8'b11_10_01_00;
    repeat (2) tick();

    // Direct: 3-cycle latency on both edges
    sig[0] = 1'b1;
    repeat (3) tick();
    chk("direct_rise_early", int'(led[0]), 0);
    tick();
    chk("direct_rise", int'(led[0]), 1);
    repeat (3) tick();
    sig[0] = 1'b0;
    repeat (3) tick();
    chk("direct_fall_early", int'(led[0]), 1);
    tick();
    chk("direct_fall", int'(led[0]), 0);

    // Stretch: single edge, then two edges three cycles apart
    hi1 = 0;
    sig[1] = 1'b1;
    repeat (20) tick();
    chk("stretch_single", hi1, 8);
    hi1 = 0;
    sig[1] = 1'b0;
    repeat (3) tick();
    sig[1] = 1'b1;
    repeat (20) tick();
    chk("stretch_retrigger", hi1, 11);

    // Blink: ch2 has been high since reset
    hi2 = 0;
    repeat (16) tick();
    chk("blink_high_count", hi2, 8);
    sig[2] = 1'b0;
    repeat (4) tick();
    hi2 = 0;
    repeat (12) tick();
    chk("blink_dark", hi2, 0);

    // Toggle: three rising edges
    sig[3] = 1'b1; repeat (4) tick(); chk("toggle_1", int'(led[3]), 1);
    sig[3] = 1'b0; repeat (2) tick();
    sig[3] = 1'b1; repeat (4) tick(); chk("toggle_2", int'(led[3]), 0);
    sig[3] = 1'b0; repeat (2) tick();
    sig[3] = 1'b1; repeat (4) tick(); chk("toggle_3", int'(led[3]), 1);
    sig[3] = 1'b0; repeat (4) tick();
    mode[7:6] = 2'd0;
    tick();
    chk("toggle_to_direct", int'(led[3]), 0);
    mode[7:6] = 2'd3;
    tick();
    chk("toggle_preserved", int'(led[3]), 1);

    // Randomised traffic with occasional mode changes and resets
    for (int n = 0; n < 500; n++) begin
      reset = ($urandom_range(0, 49) == 0);
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 5) == 0) sig[b] = ~sig[b];
      if ($urandom_range(0, 15) == 0) mode = 8'($urandom);
      tick();
    end

    // Reset in the middle of an active stretch
    reset = 1'b0;
    mode = 8'h55;
    sig = 4'b0000;
    repeat (12) tick();
    sig = 4'b1111;
    repeat (5) tick();
    chk("stretch_active", int'(led), 15);
    reset = 1'b1;
    tick();
    chk("midreset_led_n", int'(led_n), 15);
    chk("midreset_led", int'(led), 0);
    reset = 1'b0;
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
